// File: rtl/scnn_controller_np.sv
// scnn_controller_np
//   Sequenced sparse convolution controller with NUM_PE parallel lanes.
//   A start pulse in IDLE latches one IN_DIM x IN_DIM activation plane and one
//   K x K filter. Lane n owns a contiguous slice of IN_DIM/NUM_PE input rows
//   and multiplies each of its nonzero activations by every nonzero weight,
//   one product per cycle, scatter-adding into a private accumulator bank.
//   The banks are summed elementwise and streamed out in raster order.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           job request, sampled only in IDLE
//   in_acts         activations, element r*IN_DIM+c at [(r*IN_DIM+c)*DATA_W +: DATA_W]
//   weights         filter, element i*K+j, same packing
//   busy            high from LOAD through DRAIN
//   done            one-cycle pulse after the last output is accepted
//   out_valid/out_ready/out_idx/out_data   raster-order result stream
//   nnz_w           nonzero weight count of the latched filter
//   run_cycles      RUN-state cycle count of the last job (saturating)
module scnn_controller_np #(
  parameter int NUM_PE = 4,
  parameter int IN_DIM = 8,
  parameter int K      = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]      in_acts,
  input  logic [K*K*DATA_W-1:0]                weights,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(IN_DIM*IN_DIM)-1:0]     out_idx,
  output logic [ACC_W-1:0]                     out_data,
  output logic [$clog2(K*K+1)-1:0]             nnz_w,
  output logic [15:0]                          run_cycles
);

  localparam int NN   = IN_DIM * IN_DIM;
  localparam int NW   = K * K;
  localparam int P    = K / 2;
  localparam int ROWS = IN_DIM / NUM_PE;
  localparam int SL   = ROWS * IN_DIM;
  localparam int IW   = $clog2(NN);
  localparam int WI   = (NW > 1) ? $clog2(NW) : 1;
  localparam int WW   = $clog2(NW + 1);
  localparam int CW   = $clog2(SL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic signed [DATA_W-1:0] act_q [NN];
  logic signed [DATA_W-1:0] w_q   [NW];

  logic [WW-1:0]           w_cnt;
  logic [WI-1:0]           w_first;
  logic                    w_first_ok;
  logic [NUM_PE*ACC_W-1:0] lane_rd;
  logic [NUM_PE*32-1:0]    lane_len;
  logic [31:0]             run_max;
  logic [31:0]             run_len;
  logic [31:0]             run_cnt;
  logic [ACC_W-1:0]        drain_sum;

  // Operand capture; later port changes cannot disturb a running job.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      for (int unsigned e = 0; e < NN; e++)
        act_q[IW'(e)] <= in_acts[e*DATA_W +: DATA_W];
      for (int unsigned j = 0; j < NW; j++)
        w_q[WI'(j)] <= weights[j*DATA_W +: DATA_W];
    end
  end

  // Filter-wide nonzero count and first nonzero tap (shared by all lanes).
  always_comb begin
    w_cnt      = '0;
    w_first    = '0;
    w_first_ok = 1'b0;
    for (int unsigned j = 0; j < NW; j++) begin
      if (w_q[WI'(j)] != '0) begin
        w_cnt = w_cnt + WW'(1);
        if (!w_first_ok) begin
          w_first    = WI'(j);
          w_first_ok = 1'b1;
        end
      end
    end
  end

  for (genvar gn = 0; gn < NUM_PE; gn++) begin : g_lane
    logic [ACC_W-1:0]          bank [NN];
    logic [IW-1:0]             ap, a_first, a_next;
    logic                      a_first_ok, a_next_ok;
    logic [CW-1:0]             l_cnt;
    logic [WI-1:0]             wp, w_next;
    logic                      w_next_ok;
    logic                      on;
    logic signed [2*DATA_W-1:0] prod;
    logic [IW-1:0]             tgt;
    logic                      tgt_ok;

    // Priority encoders: first/next nonzero activation in this lane's slice
    // and next nonzero weight after the current tap. Zeros cost no cycles.
    always_comb begin
      a_first    = '0;
      a_first_ok = 1'b0;
      a_next     = '0;
      a_next_ok  = 1'b0;
      l_cnt      = '0;
      w_next     = '0;
      w_next_ok  = 1'b0;
      for (int unsigned k = 0; k < SL; k++) begin
        if (act_q[IW'(gn*SL + k)] != '0) begin
          l_cnt = l_cnt + CW'(1);
          if (!a_first_ok) begin
            a_first    = IW'(k);
            a_first_ok = 1'b1;
          end
          if (!a_next_ok && IW'(k) > ap) begin
            a_next    = IW'(k);
            a_next_ok = 1'b1;
          end
        end
      end
      for (int unsigned j = 0; j < NW; j++) begin
        if (w_q[WI'(j)] != '0 && !w_next_ok && WI'(j) > wp) begin
          w_next    = WI'(j);
          w_next_ok = 1'b1;
        end
      end
    end

    // Scatter target: input (x,y) times tap (i,j) lands on (x-i+P, y-j+P).
    always_comb begin : tgt_calc
      int x, y, r, c;
      x      = gn*ROWS + int'(ap) / IN_DIM;
      y      = int'(ap) % IN_DIM;
      r      = x - int'(wp) / K + P;
      c      = y - int'(wp) % K + P;
      tgt_ok = (r >= 0) && (r < IN_DIM) && (c >= 0) && (c < IN_DIM);
      tgt    = IW'(r*IN_DIM + c);
      prod   = (2*DATA_W)'(act_q[IW'(gn*SL) + ap]) * (2*DATA_W)'(w_q[wp]);
    end

    // Weight is the inner loop: on exhausting taps, wrap and step the input.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ap <= '0;
        wp <= '0;
        on <= 1'b0;
      end else if (state == S_LOAD) begin
        ap <= a_first;
        wp <= w_first;
        on <= a_first_ok & w_first_ok;
      end else if (state == S_RUN && on) begin
        if (w_next_ok) begin
          wp <= w_next;
        end else begin
          wp <= w_first;
          if (a_next_ok) ap <= a_next;
          else           on <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (state == S_LOAD) begin
        for (int unsigned e = 0; e < NN; e++)
          bank[IW'(e)] <= '0;
      end else if (state == S_RUN && on && tgt_ok) begin
        bank[tgt] <= bank[tgt] + ACC_W'(prod);
      end
    end

    assign lane_rd[gn*ACC_W +: ACC_W] = bank[out_idx];
    assign lane_len[gn*32 +: 32]      = 32'(l_cnt) * 32'(w_cnt);
  end

  always_comb begin
    run_max = '0;
    for (int unsigned n = 0; n < NUM_PE; n++)
      if (lane_len[n*32 +: 32] > run_max) run_max = lane_len[n*32 +: 32];
  end

  always_comb begin
    drain_sum = '0;
    for (int unsigned n = 0; n < NUM_PE; n++)
      drain_sum = drain_sum + lane_rd[n*ACC_W +: ACC_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      out_idx    <= '0;
      nnz_w      <= '0;
      run_cycles <= '0;
      run_len    <= '0;
      run_cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_LOAD: begin
          nnz_w      <= w_cnt;
          run_cycles <= '0;
          run_len    <= run_max;
          run_cnt    <= '0;
          out_idx    <= '0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (run_cycles != '1) run_cycles <= run_cycles + 16'd1;
        end
        S_DRAIN: begin
          if (out_ready) out_idx <= out_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        state_nx = (run_max == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (run_cnt == run_len - 32'd1) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = drain_sum;
        if (out_ready && out_idx == IW'(NN - 1)) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/scnn_controller_np.md
Name: scnn_controller_np

Overview:
- Parametrised, sequenced successor to the fixed 4-PE sparse convolution controller.
- Latches one IN_DIM x IN_DIM activation plane and one K x K filter on a start handshake.
- Splits the plane into NUM_PE row slices; each PE lane multiplies its nonzero activations by every nonzero weight, one product per lane per cycle, and scatter-adds into a private accumulator bank.
- Sums the banks elementwise and streams the IN_DIM*IN_DIM results out over a valid/ready port in raster order.

Parameters:
- NUM_PE, 4, number of PE lanes; must divide IN_DIM.
- IN_DIM, 8, activation plane side; outputs are the same size.
- K, 3, filter side (odd); padding P = K/2.
- DATA_W, 16, signed activation and weight width.
- ACC_W, 32, signed accumulator and output width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request; sampled only in IDLE.
- in_acts, input, IN_DIM*IN_DIM*DATA_W, activations, element r*IN_DIM+c at bits [(r*IN_DIM+c)*DATA_W +: DATA_W].
- weights, input, K*K*DATA_W, filter, element i*K+j, same packing.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse after the last output is accepted.
- out_valid, output, 1, output element available.
- out_ready, input, 1, consumer accepts when out_valid & out_ready.
- out_idx, output, clog2(IN_DIM*IN_DIM), raster index of out_data.
- out_data, output, ACC_W, signed output element.
- nnz_w, output, clog2(K*K+1), nonzero weight count of the latched filter.
- run_cycles, output, 16, RUN-state cycle count of the last job; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, out_valid = 0; out_idx, out_data, nnz_w, run_cycles = 0. Accumulator contents are don't-care.
- Math: out[r][c] = sum over i,j of in[r+i-P][c+j-P]*w[i][j]; out-of-range taps contribute 0. Equivalently, nonzero input (x,y) times nonzero weight (i,j) adds to out[x-i+P][y-j+P] when that position is in range; out-of-range products are dropped.
- Products are 2*DATA_W signed, sign-extended to ACC_W. Sums wrap modulo 2^ACC_W with no saturation.
- Lane n owns input rows [n*IN_DIM/NUM_PE, (n+1)*IN_DIM/NUM_PE).
- IDLE:
  - start=1 latches in_acts and weights, then goes to LOAD.
  - start=0: stay in IDLE.
- LOAD (1 cycle):
  - Clear all accumulator banks.
  - Compute nnz_w and per-lane nonzero input counts L[n].
  - Reset all lane pointers and run_cycles.
  - Set busy=1.
  - If max L[n]*nnz_w == 0, go to DRAIN; otherwise go to RUN.
- RUN:
  - Each active lane issues one (input, weight) product per cycle. Weight index is the inner loop; input index is the outer loop. Zero elements are skipped by priority encoders at zero cycle cost.
  - A lane that has finished idles.
  - run_cycles increments each cycle.
  - Leave for DRAIN after exactly max over n of L[n]*nnz_w cycles.
  - Accumulator update is registered; the final write lands before the first DRAIN read.
- DRAIN:
  - out_valid=1 and out_data = sum of the NUM_PE bank entries at out_idx (combinational sum).
  - out_idx advances only on out_valid & out_ready.
  - While stalled, out_data and out_idx hold stable.
  - After accepting index IN_DIM*IN_DIM-1, go to DONE.
- DONE (1 cycle): done=1, busy=0, out_valid=0, then IDLE.
- start is ignored outside IDLE.
- Input port changes after latching do not affect the running job.
- rst asserted mid-job aborts immediately to the reset state; the next start runs a fresh job correctly.
- nnz_w and run_cycles hold their values until the next LOAD.

Test Plan:
- Filter with only the centre tap = 1; in = ramp 1..64; defaults -> outputs 1..64 in order, L[n]=16, run_cycles=16, nnz_w=1.
- All-zero activations with any filter -> RUN skipped (run_cycles=0); 64 zero outputs; done pulses 1 cycle after the last accept.
- All-ones activations and all-ones filter -> corner outputs 4, edge outputs 6, interior outputs 9; run_cycles=144, nnz_w=9.
- Same as the previous case with out_ready toggled pseudo-randomly -> exactly 64 transfers, idx 0..63 with no skips or repeats; data and idx stable while out_valid & !out_ready.
- Activation 0x7FFF at (0,0), filter -1 at the centre, others 0 -> out[0] = 0xFFFF8001 and all other outputs 0. In the same job, a start pulse issued mid-RUN has no effect.
- rst asserted at RUN cycle 5 -> busy and out_valid are 0 immediately. A following job with NUM_PE=2 (elaborated variant) and the ramp/centre filter -> outputs 1..64, run_cycles=32.
